// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: state encodings and shared constants for the divide controller
// and the iterative divider it drives.
package div_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10, DRAIN = 2'b11} state_t;
   typedef enum logic [1:0] {D_IDLE = 2'b00, D_RUN = 2'b01, D_FIX = 2'b10, D_OUT = 2'b11} dstate_t;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam int DRAIN_CYC_DEF = 2;
endpackage

// File: rtl/div.sv
// div: radix-2 restoring divider on magnitudes with a final sign fix-up; ready
// 34 cycles after the start it accepts, 2 cycles for a zero divisor (result 0/0).
module div
   import div_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        signed_div,
   input  logic [31:0] opdata1,
   input  logic [31:0] opdata2,
   input  logic        start,
   input  logic        annul,
   output logic [63:0] result,
   output logic        ready
);
   dstate_t     st;
   logic [4:0]  cnt;
   logic [31:0] q, r, d, a1, a2;
   logic        neg_q, neg_r, zero;
   logic [32:0] trial;
   assign zero   = opdata2 == ZERO_WORD;
   assign a1     = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
   assign a2     = (signed_div && opdata2[31]) ? -opdata2 : opdata2;
   assign trial  = {r, q[31]} - {1'b0, d};
   assign ready  = st == D_OUT;
   assign result = {r, q};
   always_ff @(posedge clk) begin
      if (!resetn || annul) begin
         st    <= D_IDLE;
         cnt   <= '0;
         q     <= '0;
         r     <= '0;
         d     <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         case (st)
            D_IDLE: if (start) begin
               q     <= zero ? ZERO_WORD : a1;
               r     <= ZERO_WORD;
               d     <= a2;
               cnt   <= '0;
               neg_q <= signed_div && !zero && (opdata1[31] ^ opdata2[31]);
               neg_r <= signed_div && !zero && opdata1[31];
               st    <= zero ? D_FIX : D_RUN;
            end
            D_RUN: begin
               // a borrow out of the trial subtraction means the shifted remainder is below d
               r   <= trial[32] ? {r[30:0], q[31]} : trial[31:0];
               q   <= {q[30:0], ~trial[32]};
               cnt <= cnt + 5'd1;
               st  <= cnt == 5'd31 ? D_FIX : D_RUN;
            end
            D_FIX: begin
               q  <= neg_q ? -q : q;
               r  <= neg_r ? -r : r;
               st <= D_OUT;
            end
            D_OUT: st <= D_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for DIV/DIVU; holds the pipeline while the external
// divider runs, writes HI/LO once on completion, and annuls the divider on flush.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_div_req,
   input  logic        ex_div_signed,
   input  logic [31:0] ex_rs,
   input  logic [31:0] ex_rt,
   input  logic        flush,
   input  logic        ext_stall,
   output logic        stall_o,
   output logic        hilo_we,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [31:0] div_opdata1,
   output logic [31:0] div_opdata2,
   output logic        div_signed,
   output logic        div_start,
   output logic        div_annul,
   input  logic [63:0] div_result,
   input  logic        div_ready
);
   localparam int CW = $clog2(DRAIN_CYC + 1);
   state_t        state;
   logic [CW-1:0] drain_cnt;
   logic [31:0]   op1, op2;
   logic          sgn;
   logic          busy;
   assign busy        = state == BUSY;
   assign div_opdata1 = busy ? op1 : ZERO_WORD;
   assign div_opdata2 = busy ? op2 : ZERO_WORD;
   assign div_signed  = busy & sgn;
   always_comb
      stall_o = state == IDLE  ? ex_div_req & ~flush :
                state == BUSY  ? 1'b1 :
                state == DRAIN ? ex_div_req : 1'b0;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         drain_cnt <= '0;
         op1       <= ZERO_WORD;
         op2       <= ZERO_WORD;
         sgn       <= 1'b0;
         hi_o      <= ZERO_WORD;
         lo_o      <= ZERO_WORD;
         hilo_we   <= 1'b0;
         div_start <= 1'b0;
         div_annul <= 1'b0;
      end else begin
         hilo_we <= 1'b0;
         case (state)
            IDLE: if (ex_div_req && !flush) begin
               op1       <= ex_rs;
               op2       <= ex_rt;
               sgn       <= ex_div_signed;
               div_start <= 1'b1;
               state     <= BUSY;
            end
            BUSY: if (flush) begin
               div_start <= 1'b0;
               div_annul <= 1'b1;
               drain_cnt <= CW'(DRAIN_CYC - 1);
               state     <= DRAIN;
            end else if (div_ready) begin
               hi_o      <= div_result[63:32];
               lo_o      <= div_result[31:0];
               hilo_we   <= 1'b1;
               div_start <= 1'b0;
               state     <= DONE;
            end
            // a flush here squashes downstream; the HI/LO write already issued stands
            DONE: if (flush || !ext_stall) state <= IDLE;
            DRAIN: if (drain_cnt == '0) begin
               div_annul <= 1'b0;
               state     <= IDLE;
            end else begin
               drain_cnt <= drain_cnt - CW'(1);
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl running beside the div model.
module tb_div_ctrl;
   logic        clk = 1'b0;
   logic        resetn, ex_div_req, ex_div_signed, flush, ext_stall;
   logic [31:0] ex_rs, ex_rt;
   logic        stall_o, hilo_we, div_signed, div_start, div_annul, div_ready;
   logic [31:0] hi_o, lo_o, div_opdata1, div_opdata2;
   logic [63:0] div_result;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   div_ctrl #(.DRAIN_CYC(2)) u_ctrl (
      .clk(clk), .resetn(resetn), .ex_div_req(ex_div_req), .ex_div_signed(ex_div_signed),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .ext_stall(ext_stall),
      .stall_o(stall_o), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o),
      .div_opdata1(div_opdata1), .div_opdata2(div_opdata2), .div_signed(div_signed),
      .div_start(div_start), .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready)
   );

   div u_div (
      .clk(clk), .resetn(resetn), .signed_div(div_signed), .opdata1(div_opdata1),
      .opdata2(div_opdata2), .start(div_start), .annul(div_annul),
      .result(div_result), .ready(div_ready)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issues one request, holds it while stalled, then drops it after the DONE cycle.
   task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int wes, output logic to);
      stalls = 0;
      wes = 0;
      to = 1'b1;
      ex_div_req = 1'b1;
      ex_div_signed = sg;
      ex_rs = a;
      ex_rt = b;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (hilo_we) wes++;
         if (!stall_o) begin
            to = 1'b0;
            break;
         end
         stalls++;
         tick();
      end
      ex_div_req = 1'b0;
      ex_rs = '0;
      ex_rt = '0;
      tick();
      #1;
      if (hilo_we) wes++;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      tick();
      tick();
      #1;
      n_total++; if (stall_o !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", stall_o); else n_pass++;
      n_total++; if (hilo_we !== 1'b0) $display("FAIL reset_hilo_we got=%0b exp=0", hilo_we); else n_pass++;
      n_total++; if ({hi_o, lo_o} !== 64'h0) $display("FAIL reset_hilo got=%h exp=0", {hi_o, lo_o}); else n_pass++;
      n_total++; if ({div_start, div_annul, div_signed} !== 3'b000) $display("FAIL reset_ctl got=%b exp=000", {div_start, div_annul, div_signed}); else n_pass++;
      n_total++; if ({div_opdata1, div_opdata2} !== 64'h0) $display("FAIL reset_opdata got=%h exp=0", {div_opdata1, div_opdata2}); else n_pass++;
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_divu;
      int s, w;
      logic to;
      run_div(1'b0, 32'd100, 32'd7, s, w, to);
      n_total++; if (to !== 1'b0) $display("FAIL divu_timeout got=%0b exp=0", to); else n_pass++;
      n_total++; if (s != 36) $display("FAIL divu_stall_cycles got=%0d exp=36", s); else n_pass++;
      n_total++; if (w != 1) $display("FAIL divu_hilo_we got=%0d exp=1", w); else n_pass++;
      n_total++; if (hi_o !== 32'd2) $display("FAIL divu_hi got=%h exp=2", hi_o); else n_pass++;
      n_total++; if (lo_o !== 32'd14) $display("FAIL divu_lo got=%h exp=e", lo_o); else n_pass++;
   endtask

   task automatic test_div_signed;
      int s, w;
      logic to;
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, s, w, to);
      n_total++; if (w != 1 || to) $display("FAIL div_m7_2_we got=%0d exp=1", w); else n_pass++;
      n_total++; if (lo_o !== 32'hFFFF_FFFD) $display("FAIL div_m7_2_lo got=%h exp=fffffffd", lo_o); else n_pass++;
      n_total++; if (hi_o !== 32'hFFFF_FFFF) $display("FAIL div_m7_2_hi got=%h exp=ffffffff", hi_o); else n_pass++;
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, s, w, to);
      n_total++; if (w != 1 || to) $display("FAIL div_7_m2_we got=%0d exp=1", w); else n_pass++;
      n_total++; if (lo_o !== 32'hFFFF_FFFD) $display("FAIL div_7_m2_lo got=%h exp=fffffffd", lo_o); else n_pass++;
      n_total++; if (hi_o !== 32'd1) $display("FAIL div_7_m2_hi got=%h exp=1", hi_o); else n_pass++;
   endtask

   task automatic test_div_zero;
      int s, w;
      logic to;
      run_div(1'b1, 32'h0000_1234, 32'd0, s, w, to);
      n_total++; if (s != 4 || to) $display("FAIL divzero_stall_cycles got=%0d exp=4", s); else n_pass++;
      n_total++; if (w != 1) $display("FAIL divzero_hilo_we got=%0d exp=1", w); else n_pass++;
      n_total++; if ({hi_o, lo_o} !== 64'h0) $display("FAIL divzero_result got=%h exp=0", {hi_o, lo_o}); else n_pass++;
   endtask

   task automatic test_flush_busy;
      int s, w, bad, ann;
      logic to;
      bad = 0;
      w = 0;
      ann = 0;
      ex_div_req = 1'b1;
      ex_div_signed = 1'b1;
      ex_rs = 32'hFFFF_FFCE;
      ex_rt = 32'd5;
      #1;
      n_total++; if (stall_o !== 1'b1) $display("FAIL accept_stall got=%0b exp=1", stall_o); else n_pass++;
      tick();
      #1;
      n_total++; if ({div_start, div_annul, div_signed} !== 3'b101) $display("FAIL busy_ctl got=%b exp=101", {div_start, div_annul, div_signed}); else n_pass++;
      n_total++; if ({div_opdata1, div_opdata2} !== {32'hFFFF_FFCE, 32'd5}) $display("FAIL busy_opdata got=%h exp=ffffffce00000005", {div_opdata1, div_opdata2}); else n_pass++;
      for (int i = 2; i <= 10; i++) begin
         tick();
         #1;
         if (div_opdata1 !== 32'hFFFF_FFCE || div_opdata2 !== 32'd5 || !div_start || !stall_o) bad++;
         if (hilo_we) w++;
      end
      n_total++; if (bad != 0) $display("FAIL busy_stable got=%0d exp=0", bad); else n_pass++;
      flush = 1'b1;
      ex_div_req = 1'b0;
      tick();
      flush = 1'b0;
      ex_div_req = 1'b1;
      ex_div_signed = 1'b0;
      ex_rs = 32'd77;
      ex_rt = 32'd8;
      #1;
      if (div_annul) ann++;
      if (hilo_we) w++;
      n_total++; if ({div_start, stall_o, div_signed} !== 3'b010) $display("FAIL drain_ctl got=%b exp=010", {div_start, stall_o, div_signed}); else n_pass++;
      n_total++; if (div_opdata1 !== 32'h0) $display("FAIL drain_opdata got=%h exp=0", div_opdata1); else n_pass++;
      tick();
      #1;
      if (div_annul) ann++;
      if (hilo_we) w++;
      tick();
      #1;
      if (div_annul) ann++;
      n_total++; if (ann != 2) $display("FAIL flush_annul_cycles got=%0d exp=2", ann); else n_pass++;
      n_total++; if (w != 0) $display("FAIL flush_hilo_we got=%0d exp=0", w); else n_pass++;
      run_div(1'b0, 32'd77, 32'd8, s, w, to);
      n_total++; if (s != 36 || w != 1 || to) $display("FAIL after_flush_timing got=%0d/%0d exp=36/1", s, w); else n_pass++;
      n_total++; if ({hi_o, lo_o} !== {32'd5, 32'd9}) $display("FAIL after_flush_result got=%h exp=0000000500000009", {hi_o, lo_o}); else n_pass++;
   endtask

   task automatic test_ext_stall;
      int s, w, sbad, hbad;
      logic to;
      w = 0;
      to = 1'b1;
      sbad = 0;
      hbad = 0;
      ex_div_req = 1'b1;
      ex_div_signed = 1'b0;
      ex_rs = 32'd100;
      ex_rt = 32'd7;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (hilo_we) w++;
         if (!stall_o) begin
            to = 1'b0;
            break;
         end
         tick();
      end
      ext_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            tick();
            #1;
            if (hilo_we) w++;
         end
         if (stall_o !== 1'b0) sbad++;
         if (hi_o !== 32'd2 || lo_o !== 32'd14) hbad++;
      end
      tick();
      ext_stall = 1'b0;
      #1;
      if (hilo_we) w++;
      if (stall_o !== 1'b0) sbad++;
      n_total++; if (to !== 1'b0) $display("FAIL xstall_timeout got=%0b exp=0", to); else n_pass++;
      n_total++; if (w != 1) $display("FAIL xstall_hilo_we got=%0d exp=1", w); else n_pass++;
      n_total++; if (sbad != 0) $display("FAIL xstall_done_stall got=%0d exp=0", sbad); else n_pass++;
      n_total++; if (hbad != 0) $display("FAIL xstall_hold got=%0d exp=0", hbad); else n_pass++;
      tick();
      run_div(1'b0, 32'd9, 32'd3, s, w, to);
      n_total++; if (s != 36 || w != 1 || lo_o !== 32'd3) $display("FAIL xstall_idle_after got=%0d/%0d/%h exp=36/1/3", s, w, lo_o); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int s1, w1, s2, w2;
      logic t1, t2;
      logic [63:0] r1;
      run_div(1'b0, 32'hFFFF_FFFF, 32'd1, s1, w1, t1);
      r1 = {hi_o, lo_o};
      run_div(1'b0, 32'd9, 32'd3, s2, w2, t2);
      n_total++; if (w1 != 1 || w2 != 1 || t1 || t2) $display("FAIL b2b_hilo_we got=%0d,%0d exp=1,1", w1, w2); else n_pass++;
      n_total++; if (r1 !== {32'd0, 32'hFFFF_FFFF}) $display("FAIL b2b_first got=%h exp=00000000ffffffff", r1); else n_pass++;
      n_total++; if ({hi_o, lo_o} !== {32'd0, 32'd3}) $display("FAIL b2b_second got=%h exp=0000000000000003", {hi_o, lo_o}); else n_pass++;
      n_total++; if (s2 != 36) $display("FAIL b2b_no_bubble got=%0d exp=36", s2); else n_pass++;
   endtask

   task automatic test_flush_idle_done;
      int w;
      ex_div_req = 1'b1;
      flush = 1'b1;
      ex_rs = 32'd20;
      ex_rt = 32'd6;
      ex_div_signed = 1'b0;
      #1;
      n_total++; if (stall_o !== 1'b0) $display("FAIL idle_flush_stall got=%0b exp=0", stall_o); else n_pass++;
      tick();
      flush = 1'b0;
      ex_div_req = 1'b0;
      #1;
      n_total++; if (div_start !== 1'b0) $display("FAIL idle_flush_ignored got=%0b exp=0", div_start); else n_pass++;
      ex_div_req = 1'b1;
      w = 0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (hilo_we) w++;
         if (!stall_o) break;
         tick();
      end
      flush = 1'b1;
      ext_stall = 1'b1;
      tick();
      flush = 1'b0;
      ex_rs = 32'd40;
      #1;
      if (hilo_we) w++;
      n_total++; if (stall_o !== 1'b1) $display("FAIL done_flush_idle got=%0b exp=1", stall_o); else n_pass++;
      n_total++; if (w != 1 || {hi_o, lo_o} !== {32'd2, 32'd3}) $display("FAIL done_flush_result got=%0d/%h exp=1/0000000200000003", w, {hi_o, lo_o}); else n_pass++;
      ex_div_req = 1'b0;
      ext_stall = 1'b0;
      tick();
      #1;
      n_total++; if (div_start !== 1'b0) $display("FAIL done_flush_no_start got=%0b exp=0", div_start); else n_pass++;
   endtask

   task automatic test_reset_mid_busy;
      int w, rdy;
      w = 0;
      rdy = 0;
      ex_div_req = 1'b1;
      ex_div_signed = 1'b0;
      ex_rs = 32'd1000;
      ex_rt = 32'd3;
      for (int i = 0; i < 6; i++) tick();
      resetn = 1'b0;
      ex_div_req = 1'b0;
      tick();
      #1;
      n_total++; if ({stall_o, hilo_we, div_start, div_annul, div_signed} !== 5'b0) $display("FAIL rst_busy_ctl got=%b exp=00000", {stall_o, hilo_we, div_start, div_annul, div_signed}); else n_pass++;
      n_total++; if ({hi_o, lo_o, div_opdata1, div_opdata2} !== 128'h0) $display("FAIL rst_busy_data got=%h exp=0", {hi_o, lo_o}); else n_pass++;
      resetn = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         #1;
         if (hilo_we) w++;
         if (div_ready) rdy++;
      end
      n_total++; if (w != 0 || rdy != 0) $display("FAIL rst_busy_abandon got=%0d/%0d exp=0/0", w, rdy); else n_pass++;
   endtask

   initial begin
      resetn = 1'b0;
      ex_div_req = 1'b0;
      ex_div_signed = 1'b0;
      ex_rs = '0;
      ex_rt = '0;
      flush = 1'b0;
      ext_stall = 1'b0;
      test_reset();
      test_divu();
      test_div_signed();
      test_div_zero();
      test_flush_busy();
      test_ext_stall();
      test_back_to_back();
      test_flush_idle_done();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
